mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEBUG, default 0; when 1, $display each accepted request and each misaligned access.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  1  memory instruction present in EX/MEM register.
REQ-005 req_write  in  1  1 = store, 0 = load.
REQ-006 req_size  in  2  00 byte, 01 halfword, 10 word; 11 illegal, treated as misaligned.
REQ-007 req_signed  in  1  sign-extend sub-word loads (LB/LH) when 1, zero-extend when 0.
REQ-008 req_addr  in  `ADDR_SIZE  byte address.
REQ-009 req_wdata  in  `WORD_SIZE  store data, right-justified.
REQ-010 stall  out  1  hold upstream pipeline; request inputs held stable while high.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  `WORD_SIZE  extended load result; 0 for stores and faults.
REQ-013 misalign  out  1  fault flag, valid only with rsp_valid.
REQ-014 mem_addr  out  `ADDR_SIZE  word-aligned address to data memory (bits [1:0] = 0).
REQ-015 mem_wdata  out  `WORD_SIZE  write data to data memory.
REQ-016 mem_read / mem_write  out  1 each  data-memory strobes.
REQ-017 mem_rdata  in  `WORD_SIZE  data-memory read data, sampled at the posedge after mem_read is issued.

Function
REQ-018 FSM states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP; request accepted at posedge when state = IDLE and req_valid = 1.
REQ-019 Transitions from IDLE: misaligned -> RESP; load -> LOAD; word store -> STORE; byte/half store -> RMW_RD.
REQ-020 Transitions: LOAD -> RESP; STORE -> RESP; RMW_RD -> RMW_WR; RMW_WR -> RESP; RESP -> IDLE.
REQ-021 Misaligned: half with addr[0] = 1, word with addr[1:0] != 0, or size = 11.
REQ-022 Latency from accept to rsp_valid: LW 2 cycles, SW 2, SB/SH 3, fault 1.
REQ-023 stall = 1 when (IDLE and req_valid) or state in {LOAD, STORE, RMW_RD, RMW_WR}; stall = 0 in RESP, so the pipeline advances on the RESP edge.
REQ-024 Request fields latched at accept; later input changes are ignored until IDLE.
REQ-025 mem_read = 1 only in LOAD and RMW_RD; mem_write = 1 only in STORE and RMW_WR; the two are never high together.
REQ-026 Outside read/write states: mem_addr = 0 and mem_wdata = 0.
REQ-027 Lanes are big-endian: byte offset 0 maps to bits [31:24], halfword offset 0 maps to bits [31:16].
REQ-028 RMW_RD captures mem_rdata; RMW_WR writes the captured word with only the addressed lane replaced by req_wdata[7:0] or [15:0].
REQ-029 Loads extract the addressed lane from mem_rdata captured at the LOAD->RESP edge, then sign- or zero-extend to `WORD_SIZE.
REQ-030 rsp_rdata, misalign and rsp_valid are registered, valid only in RESP, and 0 otherwise.
REQ-031 In IDLE with req_valid = 0: no memory strobe and stall = 0.

Reset
REQ-032 rst at a posedge forces IDLE and zeros all outputs and latched fields from the next cycle, including mid-RMW; a partial RMW_RD issues no write.
REQ-033 rst takes priority over acceptance of a request on the same edge.

Configuration
REQ-034 With MAU_SUBWORD_EN defined: byte and halfword accesses behave as specified above.
REQ-035 Without MAU_SUBWORD_EN: RMW states are not built, any req_size != 10 is treated as misaligned, and the LOAD path returns the raw word.

Structure
REQ-036 defs.v holds `ADDR_SIZE, `WORD_SIZE, the req_size encodings and the FSM state encodings.
REQ-037 Lane extraction/extension and store merge live in one combinational sub-module, mau_lane_align, instantiated once.

Verification
REQ-038 Memory word 0x1 = 0x8899AABB; LB addr 0x5 signed -> rsp_rdata = 0xFFFFFF99, rsp_valid 2 cycles after accept; LBU -> 0x00000099.
REQ-039 SB addr 0x6 data 0x11 over 0x8899AABB -> one read, then one write of 0x889911BB to word address 0x4; rsp_valid 3 cycles after accept.
REQ-040 LH addr 0x3 -> misalign = 1 and rsp_valid 1 cycle after accept; no mem_read or mem_write ever asserted.
REQ-041 Back-to-back SW 0x8 = 0xDEADBEEF then LW 0x8 -> 0xDEADBEEF; stall low exactly one cycle between the two requests.
REQ-042 rst asserted in RMW_RD of an SH -> next cycle IDLE with all outputs 0; memory word unchanged.
REQ-043 Build without MAU_SUBWORD_EN: LB addr 0x4 -> misalign = 1; LW addr 0x4 -> 0x8899AABB.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared widths, request-size and FSM encodings for the data-memory access unit.
// Sub-word (byte/halfword) support is enabled by defining MAU_SUBWORD_EN.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package mem_access_unit_pkg;

  localparam int unsigned ADDR_W = `ADDR_SIZE;
  localparam int unsigned WORD_W = `WORD_SIZE;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } req_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } mau_state_e;

  typedef struct packed {
    req_size_e         size;
    logic              sign;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mau_req_t;

  // Alignment fault for a given access size and byte offset within the word.
  function automatic logic is_misaligned(input req_size_e size, input logic [1:0] offset);
    logic fault;
`ifdef MAU_SUBWORD_EN
    case (size)
      SIZE_BYTE: fault = 1'b0;
      SIZE_HALF: fault = offset[0];
      SIZE_WORD: fault = (offset != 2'b00);
      default:   fault = 1'b1;
    endcase
`else
    fault = (size != SIZE_WORD) || (offset != 2'b00);
`endif
    return fault;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for sub-word stores.
// Lane logic exists only when MAU_SUBWORD_EN is defined; otherwise words pass through.
module mau_lane_align
  import mem_access_unit_pkg::*;
(
  input  req_size_e         size,
  input  logic              sign,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

`ifdef MAU_SUBWORD_EN
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[WORD_W-1:16];

  // Offset 0 is the most significant lane.
  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0:    byte_lane = rdata[WORD_W-1  -: 8];
      2'd1:    byte_lane = rdata[WORD_W-9  -: 8];
      2'd2:    byte_lane = rdata[WORD_W-17 -: 8];
      default: byte_lane = rdata[WORD_W-25 -: 8];
    endcase
    half_lane = offset[1] ? rdata[WORD_W-17 -: 16] : rdata[WORD_W-1 -: 16];
  end

  always_comb begin
    load_data = rdata;
    case (size)
      SIZE_BYTE: load_data = {{(WORD_W-8){sign & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_data = {{(WORD_W-16){sign & half_lane[15]}}, half_lane};
      default:   load_data = rdata;
    endcase
  end

  always_comb begin
    merge_data = rdata;
    if (size == SIZE_BYTE) begin
      case (offset)
        2'd0:    merge_data[WORD_W-1  -: 8] = wdata[7:0];
        2'd1:    merge_data[WORD_W-9  -: 8] = wdata[7:0];
        2'd2:    merge_data[WORD_W-17 -: 8] = wdata[7:0];
        default: merge_data[WORD_W-25 -: 8] = wdata[7:0];
      endcase
    end else if (size == SIZE_HALF) begin
      if (offset[1]) merge_data[WORD_W-17 -: 16] = wdata[15:0];
      else           merge_data[WORD_W-1  -: 16] = wdata[15:0];
    end
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = ^{size, sign, offset};
  assign load_data   = rdata;
  assign merge_data  = wdata;
`endif

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the EX/MEM register and a single-port word data memory.
// Define MAU_SUBWORD_EN to build byte/halfword accesses (read-modify-write stores).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter bit DEBUG = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [WORD_W-1:0] mem_rdata
);

  mau_state_e        state_q, state_d;
  mau_req_t          fields_q, fields_d, req_in;
  logic              accept, fault_in;
  logic              rsp_valid_d, misalign_d, mem_read_d, mem_write_d;
  logic [WORD_W-1:0] rsp_rdata_d, mem_wdata_d, load_data, merge_data;
  logic [ADDR_W-1:0] mem_addr_d, req_word_addr, fields_word_addr;

  mau_lane_align u_lane_align (
    .size       (fields_q.size),
    .sign       (fields_q.sign),
    .offset     (fields_q.addr[1:0]),
    .rdata      (mem_rdata),
    .wdata      (fields_q.wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_in           = '{size: req_size_e'(req_size), sign: req_signed,
                              addr: req_addr, wdata: req_wdata};
  assign accept           = (state_q == ST_IDLE) && req_valid;
  assign fault_in         = is_misaligned(req_size_e'(req_size), req_addr[1:0]);
  assign req_word_addr    = {req_addr[ADDR_W-1:2], 2'b00};
  assign fields_word_addr = {fields_q.addr[ADDR_W-1:2], 2'b00};

`ifndef MAU_SUBWORD_EN
  logic unused_fields;
  assign unused_fields = ^fields_word_addr;
`endif

  // Next state plus next values of every registered output; stall is combinational.
  always_comb begin
    state_d     = state_q;
    fields_d    = fields_q;
    stall       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    misalign_d  = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          stall    = 1'b1;
          fields_d = req_in;
          if (fault_in) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            misalign_d  = 1'b1;
          end else if (!req_write) begin
            state_d    = ST_LOAD;
            mem_read_d = 1'b1;
            mem_addr_d = req_word_addr;
          end
`ifdef MAU_SUBWORD_EN
          else if (req_in.size != SIZE_WORD) begin
            state_d    = ST_RMW_RD;
            mem_read_d = 1'b1;
            mem_addr_d = req_word_addr;
          end
`endif
          else begin
            state_d     = ST_STORE;
            mem_write_d = 1'b1;
            mem_addr_d  = req_word_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      ST_LOAD: begin
        stall       = 1'b1;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_data;
      end
      ST_STORE: begin
        stall       = 1'b1;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
`ifdef MAU_SUBWORD_EN
      ST_RMW_RD: begin
        stall       = 1'b1;
        state_d     = ST_RMW_WR;
        mem_write_d = 1'b1;
        mem_addr_d  = fields_word_addr;
        mem_wdata_d = merge_data;
      end
      ST_RMW_WR: begin
        stall       = 1'b1;
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
      end
`endif
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fields_q  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      misalign  <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      fields_q  <= fields_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      misalign  <= misalign_d;
      mem_read  <= mem_read_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
    end
  end

  if (DEBUG) begin : g_debug
    always_ff @(posedge clk) begin
      if (!rst && accept) begin
        $display("mau: accept %s size=%0d addr=%h wdata=%h",
                 req_write ? "store" : "load", req_size, req_addr, req_wdata);
        if (fault_in) $display("mau: misaligned access size=%0d addr=%h", req_size, req_addr);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a small word-addressed memory model.
// Exercises the sub-word paths only when MAU_SUBWORD_EN is defined.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, misalign, mem_read, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:15];
  logic        mem_init, mon_en;
  bit          back_to_back;
  int unsigned cyc = 0;
  int          n_checks = 0, n_err = 0;
  int          n_rd = 0, n_wr = 0;
  logic [31:0] last_wr_addr, last_wr_data;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int unsigned cyc;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  mem_access_unit #(.DEBUG(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .misalign   (misalign),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous-read, synchronous-write data memory.
  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h8899AABB;
    end else if (mem_write) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Bus invariants every cycle; responses are popped and compared when presented.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_read) n_rd++;
      if (mem_write) begin
        n_wr++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end
      check("strobe_excl", 32'(mem_read & mem_write), 32'h0);
      if (!mem_read && !mem_write) check("bus_idle", mem_addr | mem_wdata, 32'h0);
      else check("addr_align", 32'(mem_addr[1:0]), 32'h0);
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          mon_e = q.pop_front();
          check({"rdata_", mon_e.name}, rsp_rdata, mon_e.rdata);
          check({"misalign_", mon_e.name}, 32'(misalign), 32'(mon_e.mis));
          check({"latency_", mon_e.name}, 32'(cyc), 32'(mon_e.cyc));
        end
      end else begin
        check("rsp_quiet", rsp_rdata | 32'(misalign), 32'h0);
      end
    end
  end

  // Present one request at a negedge, hold it while stalled, return in the RESP cycle.
  task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input int unsigned lat);
    exp_t        e;
    int unsigned n;
    bit          done;
    e.rdata = exp_rd;
    e.mis   = exp_mis;
    e.cyc   = (back_to_back ? cyc + 1 : cyc) + lat;
    e.name  = name;
    q.push_back(e);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    n = 0;
    done = 1'b0;
    while (!done && n < 16) begin
      @(negedge clk);
      n++;
      if (!stall) done = 1'b1;
    end
    check({"done_", name}, 32'(done), 32'h1);
    check({"stall_len_", name}, 32'(n), 32'(lat + (back_to_back ? 1 : 0)));
    back_to_back = 1'b1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    back_to_back = 1'b0;
  endtask

  // Reset while the access is in its first memory cycle; no write may follow.
  task automatic reset_mid(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] wd);
    int          wr0;
    logic [31:0] word0;
    wr0   = n_wr;
    word0 = mem[addr[5:2]];
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = 1'b0;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    check("mid_read_issued", 32'(mem_read), 32'h1);
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_ctrl_zero", 32'({stall, rsp_valid, misalign, mem_read, mem_write}), 32'h0);
    check("rst_data_zero", rsp_rdata | mem_addr | mem_wdata, 32'h0);
    @(negedge clk);
    check("rst_no_write", 32'(n_wr - wr0), 32'h0);
    check("rst_mem_kept", mem[addr[5:2]], word0);
  endtask

  initial begin
    int rd0, wr0;
    rst = 1'b1; mem_init = 1'b1; mon_en = 1'b0; back_to_back = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;
    check("reset_ctrl", 32'({stall, rsp_valid, misalign, mem_read, mem_write}), 32'h0);
    check("reset_data", rsp_rdata | mem_addr | mem_wdata, 32'h0);
    mon_en = 1'b1;

    issue("lw_4", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8899AABB, 1'b0, 2);
    idle();

`ifdef MAU_SUBWORD_EN
    issue("lb_5_s",  1'b0, 2'b00, 1'b1, 32'h5, 32'h0, 32'hFFFFFF99, 1'b0, 2);
    issue("lbu_5",   1'b0, 2'b00, 1'b0, 32'h5, 32'h0, 32'h00000099, 1'b0, 2);
    issue("lb_4_s",  1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'hFFFFFF88, 1'b0, 2);
    issue("lh_6_s",  1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFFAABB, 1'b0, 2);
    issue("lhu_4",   1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 32'h00008899, 1'b0, 2);
    idle();
    rd0 = n_rd; wr0 = n_wr;
    issue("sb_6", 1'b1, 2'b00, 1'b0, 32'h6, 32'h00000011, 32'h0, 1'b0, 3);
    idle();
    check("sb_reads", 32'(n_rd - rd0), 32'h1);
    check("sb_writes", 32'(n_wr - wr0), 32'h1);
    check("sb_wr_addr", last_wr_addr, 32'h4);
    check("sb_wr_data", last_wr_data, 32'h889911BB);
    check("sb_mem", mem[1], 32'h889911BB);
    issue("sh_4", 1'b1, 2'b01, 1'b0, 32'h4, 32'hFFFF1234, 32'h0, 1'b0, 3);
    issue("lw_4_sh", 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h123411BB, 1'b0, 2);
    idle();
`else
    rd0 = n_rd; wr0 = n_wr;
    issue("lb_4_nosub", 1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'h0, 1'b1, 1);
    issue("sh_4_nosub", 1'b1, 2'b01, 1'b0, 32'h4, 32'h1234, 32'h0, 1'b1, 1);
    idle();
    check("nosub_no_strobe", 32'((n_rd - rd0) + (n_wr - wr0)), 32'h0);
    check("nosub_mem", mem[1], 32'h8899AABB);
`endif

    rd0 = n_rd; wr0 = n_wr;
    issue("lh_3",   1'b0, 2'b01, 1'b1, 32'h3, 32'h0, 32'h0, 1'b1, 1);
    issue("size11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1);
    issue("lw_a",   1'b0, 2'b10, 1'b0, 32'hA, 32'h0, 32'h0, 1'b1, 1);
    issue("sw_2",   1'b1, 2'b10, 1'b0, 32'h2, 32'h5555, 32'h0, 1'b1, 1);
    idle();
    check("fault_no_read", 32'(n_rd - rd0), 32'h0);
    check("fault_no_write", 32'(n_wr - wr0), 32'h0);

    rd0 = n_rd; wr0 = n_wr;
    issue("sw_8", 1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    issue("lw_8", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    idle();
    check("b2b_reads", 32'(n_rd - rd0), 32'h1);
    check("b2b_writes", 32'(n_wr - wr0), 32'h1);
    check("b2b_mem", mem[2], 32'hDEADBEEF);

`ifdef MAU_SUBWORD_EN
    reset_mid(1'b1, 2'b01, 32'h4, 32'h0000CAFE);
`else
    reset_mid(1'b0, 2'b10, 32'h4, 32'h0);
`endif

    // Reset wins over a request presented on the same edge.
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h8;
    @(negedge clk);
    check("rst_prio_read", 32'(mem_read), 32'h0);
    check("rst_prio_rsp", 32'(rsp_valid), 32'h0);
    rst = 1'b0;
    idle();

    issue("lw_8_post", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    idle();

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
